// File: rtl/ramp_pkg.sv
// Shared types and constants for the forward-speed ramp sequencer.
// Optional build macro used by the top: FRWRD_FAST_SIM_EN (large ramp steps).
package ramp_pkg;

    localparam int FRWRD_W = 10;
    localparam int CNT_W   = 4;
    localparam int ERR_W   = 12;

    localparam logic [FRWRD_W-1:0] MAX_FRWRD_DEF = 10'h2A0;
    localparam logic [5:0]         INC_DEF       = 6'h10;
    localparam logic [ERR_W-1:0]   ERR_TOL_DEF   = 12'h030;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TURN    = 3'd1,
        RAMP_UP = 3'd2,
        CRUISE  = 3'd3,
        RAMP_DN = 3'd4,
        SETTLE  = 3'd5
    } ramp_state_e;

    // Two's complement magnitude; 12'h800 maps to 12'h800, the largest value.
    function automatic logic [ERR_W-1:0] abs_err(input logic [ERR_W-1:0] e);
        return e[ERR_W-1] ? (~e + 12'd1) : e;
    endfunction

endpackage

// File: rtl/line_counter.sv
// Centre-line crossing counter: registered rising-edge detect on the IR level,
// saturating count with synchronous clear and count enable.
module line_counter
    import ramp_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_cntr_ir,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    logic             r_ir_q;
    logic [CNT_W-1:0] r_cnt;
    logic             w_rise;

    assign w_rise = i_cntr_ir & ~r_ir_q;
    assign o_cnt  = r_cnt;

    // Delay the IR level by one cycle so a line already under the sensor is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir_q <= 1'b0;
        end else begin
            r_ir_q <= i_cntr_ir;
        end
    end

    // Count rising edges while enabled, holding at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && w_rise && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/frwrd_ramp_ctrl.sv
// Move sequencer: turn in place, ramp forward speed up, cruise while counting
// centre-line crossings, ramp down, settle heading, then pulse done.
// Build macro FRWRD_FAST_SIM_EN: ramp step becomes INC*8 both up and down.
//
// Handshake: i_move_cmd is a one-cycle request accepted only in IDLE (o_busy low);
// completion is a one-cycle o_mv_done pulse. i_err_vld qualifies i_error per cycle.
module frwrd_ramp_ctrl
    import ramp_pkg::*;
#(
    parameter logic [FRWRD_W-1:0] MAX_FRWRD = MAX_FRWRD_DEF,
    parameter logic [5:0]         INC       = INC_DEF,
    parameter logic [ERR_W-1:0]   ERR_TOL   = ERR_TOL_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_move_cmd,
    input  logic [2:0]         i_num_sqrs,
    input  logic               i_err_vld,
    input  logic [ERR_W-1:0]   i_error,
    input  logic               i_cntrIR,
    output logic               o_moving,
    output logic [FRWRD_W-1:0] o_frwrd,
    output logic               o_mv_done,
    output logic               o_busy,
    output ramp_state_e        o_state
);

`ifdef FRWRD_FAST_SIM_EN
    localparam logic [FRWRD_W-1:0] STEP_UP = {1'b0, INC, 3'b000};
    localparam logic [FRWRD_W-1:0] STEP_DN = {1'b0, INC, 3'b000};
`else
    localparam logic [FRWRD_W-1:0] STEP_UP = {4'b0000, INC};
    localparam logic [FRWRD_W-1:0] STEP_DN = {3'b000, INC, 1'b0};
`endif

    ramp_state_e        r_state;
    ramp_state_e        w_state_nxt;
    logic [CNT_W-1:0]   r_target;
    logic [CNT_W-1:0]   w_line_cnt;
    logic [FRWRD_W-1:0] r_frwrd;
    logic [FRWRD_W-1:0] w_frwrd_nxt;
    logic               r_moving;
    logic               w_moving_nxt;
    logic               r_mv_done;
    logic               w_mv_done_nxt;
    logic               w_accept;
    logic               w_settled;
    logic               w_at_target;
    logic               w_cnt_en;
    logic [FRWRD_W:0]   w_up_sum;
    logic [FRWRD_W-1:0] w_up_sat;
    logic [FRWRD_W-1:0] w_dn_sat;

    assign w_accept    = (r_state == IDLE) && i_move_cmd;
    assign w_settled   = i_err_vld && (abs_err(i_error) < ERR_TOL);
    assign w_at_target = (w_line_cnt == r_target);
    assign w_cnt_en    = (r_state == RAMP_UP) || (r_state == CRUISE);

    // 11-bit sum so the step never wraps before the ceiling compare.
    assign w_up_sum = {1'b0, r_frwrd} + {1'b0, STEP_UP};
    assign w_up_sat = (w_up_sum >= {1'b0, MAX_FRWRD}) ? MAX_FRWRD : w_up_sum[FRWRD_W-1:0];
    assign w_dn_sat = (r_frwrd > STEP_DN) ? (r_frwrd - STEP_DN) : '0;

    assign o_frwrd   = r_frwrd;
    assign o_moving  = r_moving;
    assign o_mv_done = r_mv_done;
    assign o_busy    = (r_state != IDLE);
    assign o_state   = r_state;

    line_counter u_line_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_cntr_ir (i_cntrIR),
        .i_clr     (w_accept),
        .i_en      (w_cnt_en),
        .o_cnt     (w_line_cnt)
    );

    // Latch the crossing target (two per square) when a move is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_target <= '0;
        end else if (w_accept) begin
            r_target <= {i_num_sqrs, 1'b0};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; reaching the crossing target beats reaching cruise speed.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_move_cmd) w_state_nxt = TURN;
            TURN:    if (w_settled) w_state_nxt = RAMP_UP;
            RAMP_UP: begin
                if (w_at_target) begin
                    w_state_nxt = RAMP_DN;
                end else if (r_frwrd == MAX_FRWRD) begin
                    w_state_nxt = CRUISE;
                end
            end
            CRUISE:  if (w_at_target) w_state_nxt = RAMP_DN;
            RAMP_DN: if (r_frwrd == '0) w_state_nxt = SETTLE;
            SETTLE:  if (w_settled) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        w_frwrd_nxt   = '0;
        w_moving_nxt  = (w_state_nxt != IDLE);
        w_mv_done_nxt = (r_state == SETTLE) && w_settled;
        case (r_state)
            RAMP_UP: w_frwrd_nxt = i_err_vld ? w_up_sat : r_frwrd;
            CRUISE:  w_frwrd_nxt = MAX_FRWRD;
            RAMP_DN: w_frwrd_nxt = i_err_vld ? w_dn_sat : r_frwrd;
            default: w_frwrd_nxt = '0;
        endcase
    end

    // Output registers so no input reaches an output combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frwrd   <= '0;
            r_moving  <= 1'b0;
            r_mv_done <= 1'b0;
        end else begin
            r_frwrd   <= w_frwrd_nxt;
            r_moving  <= w_moving_nxt;
            r_mv_done <= w_mv_done_nxt;
        end
    end

endmodule

// File: tb/tb_frwrd_ramp_ctrl.sv
// Bench for frwrd_ramp_ctrl: expected speed changes and done pulses are queued
// by the stimulus; a monitor compares them as the DUT produces them.
module tb_frwrd_ramp_ctrl;
  import ramp_pkg::*;

`ifdef FRWRD_FAST_SIM_EN
  localparam logic [9:0] STEP_UP     = 10'h080;
  localparam logic [9:0] STEP_DN     = 10'h080;
  localparam int         UP_TO_MAX   = 6;
  localparam logic [9:0] PRE_MAX     = 10'h280;
  localparam int         DN_FROM_MAX = 6;
  localparam int         UP_TO_80    = 1;
  localparam int         DN_FROM_80  = 1;
`else
  localparam logic [9:0] STEP_UP     = 10'h010;
  localparam logic [9:0] STEP_DN     = 10'h020;
  localparam int         UP_TO_MAX   = 42;
  localparam logic [9:0] PRE_MAX     = 10'h290;
  localparam int         DN_FROM_MAX = 21;
  localparam int         UP_TO_80    = 8;
  localparam int         DN_FROM_80  = 4;
`endif
  localparam logic [9:0] MAX_SPD = 10'h2A0;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        move_cmd = 1'b0;
  logic [2:0]  num_sqrs = 3'd0;
  logic        err_vld = 1'b0;
  logic [11:0] error = 12'h000;
  logic        cntr_ir = 1'b0;
  logic        moving;
  logic [9:0]  frwrd;
  logic        mv_done;
  logic        busy;
  ramp_state_e state;

  always #5 clk = ~clk;

  frwrd_ramp_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_move_cmd (move_cmd),
    .i_num_sqrs (num_sqrs),
    .i_err_vld  (err_vld),
    .i_error    (error),
    .i_cntrIR   (cntr_ir),
    .o_moving   (moving),
    .o_frwrd    (frwrd),
    .o_mv_done  (mv_done),
    .o_busy     (busy),
    .o_state    (state)
  );

  // ---------------- scoreboard state ----------------
  logic [9:0] exp_q[$];
  logic [9:0] exp_done_q[$];
  logic [9:0] m_frwrd = '0;
  logic [9:0] cur_test = '0;
  logic [9:0] prev_frwrd = '0;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_move(input logic [2:0] n);
    num_sqrs = n;
    move_cmd = 1'b1;
    tick();
    move_cmd = 1'b0;
  endtask

  task automatic pulse_err(input logic [11:0] e);
    repeat (3) tick();
    error   = e;
    err_vld = 1'b1;
    tick();
    err_vld = 1'b0;
  endtask

  task automatic line_pulse();
    cntr_ir = 1'b1;
    repeat (2) tick();
    cntr_ir = 1'b0;
    repeat (2) tick();
  endtask

  task automatic wait_state(input ramp_state_e s, input int budget, input string name);
    int n = 0;
    while (state != s && n < budget) begin
      tick();
      n++;
    end
    check_eq(name, 32'(state), 32'(s));
  endtask

  // Queue the speed sequence expected for one step up / down of the model.
  task automatic push_up();
    logic [10:0] s;
    logic [9:0]  nxt;
    s   = {1'b0, m_frwrd} + {1'b0, STEP_UP};
    nxt = (s >= {1'b0, MAX_SPD}) ? MAX_SPD : s[9:0];
    if (nxt != m_frwrd) exp_q.push_back(nxt);
    m_frwrd = nxt;
  endtask

  task automatic push_dn_to_zero();
    for (int i = 0; i < 64 && m_frwrd != 10'h000; i++) begin
      m_frwrd = (m_frwrd > STEP_DN) ? (m_frwrd - STEP_DN) : 10'h000;
      exp_q.push_back(m_frwrd);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [9:0] e;
    if (frwrd !== prev_frwrd) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL frwrd_unexpected: got %0h, no change expected", frwrd);
      end else begin
        e = exp_q.pop_front();
        if (frwrd !== e) begin
          n_errors++;
          $display("FAIL frwrd_step: got %0h expected %0h", frwrd, e);
        end
      end
      prev_frwrd = frwrd;
    end
    if (mv_done === 1'b1) begin
      n_checks++;
      if (exp_done_q.size() == 0) begin
        n_errors++;
        $display("FAIL mv_done_unexpected: got pulse in test %0d, none expected", cur_test);
      end else begin
        e = exp_done_q.pop_front();
        if (e !== cur_test) begin
          n_errors++;
          $display("FAIL mv_done_test: got pulse in test %0d expected test %0d", cur_test, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    #1;
    check_eq("rst_frwrd", 32'(frwrd), 32'h0);
    check_eq("rst_moving", 32'(moving), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_mv_done", 32'(mv_done), 32'h0);
    check_eq("rst_state", 32'(state), 32'(IDLE));
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Test 2: one square, full ramp, cruise with a rejected command, ramp down, done.
    cur_test = 10'd2;
    m_frwrd  = '0;
    start_move(3'd1);
    check_eq("t2_turn", 32'(state), 32'(TURN));
    check_eq("t2_moving", 32'(moving), 32'h1);
    check_eq("t2_busy", 32'(busy), 32'h1);
    pulse_err(12'h010);
    check_eq("t2_ramp_up", 32'(state), 32'(RAMP_UP));
    check_eq("t2_frwrd_start", 32'(frwrd), 32'h0);
    for (int i = 1; i <= 42; i++) begin
      push_up();
      pulse_err(12'h010);
      if (i == UP_TO_MAX - 1) check_eq("t2_pre_max", 32'(frwrd), 32'(PRE_MAX));
      if (i == UP_TO_MAX) check_eq("t2_at_max", 32'(frwrd), 32'(MAX_SPD));
    end
    wait_state(CRUISE, 10, "t2_cruise");
    start_move(3'd5);
    check_eq("t2_busy_reject", 32'(state), 32'(CRUISE));
    push_dn_to_zero();
    line_pulse();
    check_eq("t2_one_crossing", 32'(state), 32'(CRUISE));
    line_pulse();
    wait_state(RAMP_DN, 10, "t2_ramp_dn");
    for (int i = 0; i < DN_FROM_MAX; i++) pulse_err(12'h010);
    wait_state(SETTLE, 10, "t2_settle");
    exp_done_q.push_back(10'd2);
    pulse_err(12'h010);
    wait_state(IDLE, 10, "t2_idle");
    repeat (4) tick();

    // Test 3: heading not settled holds TURN; zero squares skips cruise.
    cur_test = 10'd3;
    m_frwrd  = '0;
    start_move(3'd0);
    pulse_err(12'hF00);
    check_eq("t3_hold_state", 32'(state), 32'(TURN));
    check_eq("t3_hold_frwrd", 32'(frwrd), 32'h0);
    check_eq("t3_hold_moving", 32'(moving), 32'h1);
    pulse_err(12'h800);
    check_eq("t3_hold_800", 32'(state), 32'(TURN));
    pulse_err(12'h030);
    check_eq("t3_hold_tol", 32'(state), 32'(TURN));
    pulse_err(12'hFD0);
    check_eq("t3_hold_neg_tol", 32'(state), 32'(TURN));
    pulse_err(12'hFF0);
    check_eq("t3_ramp_up", 32'(state), 32'(RAMP_UP));
    wait_state(SETTLE, 10, "t3_settle");
    check_eq("t3_frwrd_zero", 32'(frwrd), 32'h0);
    exp_done_q.push_back(10'd3);
    pulse_err(12'h02F);
    wait_state(IDLE, 10, "t3_idle");
    repeat (4) tick();

    // Test 4: crossings complete early at speed 0x80.
    cur_test = 10'd4;
    m_frwrd  = '0;
    start_move(3'd1);
    pulse_err(12'h010);
    for (int i = 0; i < UP_TO_80; i++) begin
      push_up();
      pulse_err(12'h010);
    end
    check_eq("t4_frwrd_80", 32'(frwrd), 32'h080);
    push_dn_to_zero();
    line_pulse();
    line_pulse();
    wait_state(RAMP_DN, 10, "t4_ramp_dn");
    for (int i = 0; i < DN_FROM_80; i++) pulse_err(12'h010);
    wait_state(SETTLE, 10, "t4_settle");
    exp_done_q.push_back(10'd4);
    pulse_err(12'h010);
    wait_state(IDLE, 10, "t4_idle");
    repeat (4) tick();

    // Test 5: asynchronous reset in the middle of cruise.
    cur_test = 10'd5;
    m_frwrd  = '0;
    start_move(3'd2);
    pulse_err(12'h010);
    for (int i = 0; i < UP_TO_MAX; i++) begin
      push_up();
      pulse_err(12'h010);
    end
    wait_state(CRUISE, 10, "t5_cruise");
    exp_q.push_back(10'h000);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_frwrd", 32'(frwrd), 32'h0);
    check_eq("t5_rst_moving", 32'(moving), 32'h0);
    check_eq("t5_rst_busy", 32'(busy), 32'h0);
    check_eq("t5_rst_state", 32'(state), 32'(IDLE));
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check_eq("t5_after_state", 32'(state), 32'(IDLE));
    check_eq("t5_after_mv_done", 32'(mv_done), 32'h0);

    check_eq("frwrd_queue_drained", 32'(exp_q.size()), 32'h0);
    check_eq("done_queue_drained", 32'(exp_done_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
